shift_seq_ctrl: RTL and testbench

//  Multi-cycle shift/rotate sequencer for the 16-bit datapath. Accepts one

---
 rtl/shift_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-cycle shift/rotate sequencer. One request (data, count, op) is taken
//   over a valid/ready handshake. The log-shifter stages (1, 2, 4, ... bits)
//   are then applied one stage per clock to an internal data register. The
//   result is presented over a second valid/ready handshake.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        synchronous reset, active high, overrides everything
//   in_valid   request valid
//   in_ready   sequencer idle and able to accept a request
//   in_data    operand to shift (WIDTH bits)
//   in_cnt     shift amount (CNT_W bits)
//   in_op      00 ROL, 01 SLL, 10 ROR, 11 SRL
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_data   shifted result, zero when no result is presented
//   busy       sequencer not idle
module shift_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic [STG_W-1:0] stage_q, stage_d;

  // One candidate result per stage; the active stage picks its own.
  logic [CNT_W-1:0][WIDTH-1:0] stage_res;

  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_stage
      localparam int K = 1 << gi;
      assign stage_res[gi] =
        (op_q == OP_ROL) ? ((data_q << K) | (data_q >> (WIDTH - K))) :
        (op_q == OP_SLL) ?  (data_q << K) :
        (op_q == OP_ROR) ? ((data_q >> K) | (data_q << (WIDTH - K))) :
                            (data_q >> K);
    end
  endgenerate

  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] upper_bits;
  logic             last_stage;
  logic             done_now;

  assign shifted    = stage_res[stage_q];
  // Count bits that still have to be applied after the current stage.
  assign upper_bits = cnt_q >> (int'(stage_q) + 1);
  assign last_stage = (stage_q == STG_W'(CNT_W - 1));
  assign done_now   = last_stage || (EARLY_EXIT && (upper_bits == '0));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    stage_d = stage_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_cnt;
          op_d    = in_op;
          stage_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q[stage_q]) begin
          data_d = shifted;
        end
        stage_d = stage_q + STG_W'(1);
        if (done_now) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here means the next request is taken one cycle
        // after the pop, never on the pop edge itself.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = (state_q == DONE) ? data_q : '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl. Instance 0 has EARLY_EXIT=0 and
// instance 1 has EARLY_EXIT=1. Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// Latency: the accept edge opens cycle 1. So "out_valid L cycles after accept"
// means out_valid is first seen L-1 edges after the accept edge.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0][15:0] in_data, out_data;
  logic [1:0][3:0]  in_cnt;
  logic [1:0][1:0]  in_op;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(4), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_cnt(in_cnt[0]), .in_op(in_op[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0])
  );

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(4), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_cnt(in_cnt[1]), .in_op(in_op[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the shift one bit position at a time.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] c,
                                        input logic [1:0] o);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(c); i++) begin
      case (o)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Edges from accept edge until out_valid is first seen.
  function automatic int exp_edges(input int s, input logic [3:0] c);
    int hi;
    if (s == 0) return 4;
    hi = 0;
    for (int i = 0; i < 4; i++) if (c[i]) hi = i;
    return hi + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int s, output int edges);
    edges = 0;
    while (!out_valid[s] && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input int s, input logic [15:0] d, input logic [3:0] c,
                        input logic [1:0] o, input int stall);
    logic [15:0] exp_d;
    int          edges;
    exp_d = model(d, c, o);
    chk("in_ready_idle", {31'd0, in_ready[s]}, 32'd1);
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    in_cnt[s]   = c;
    in_op[s]    = o;
    tick();
    // Scramble the request inputs; the result must not depend on them now.
    in_valid[s] = 1'b0;
    in_data[s]  = 16'($urandom);
    in_cnt[s]   = 4'($urandom);
    in_op[s]    = 2'($urandom);
    chk("busy_after_accept", {31'd0, busy[s]}, 32'd1);
    wait_valid(s, edges);
    chk("latency", edges, exp_edges(s, c));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_hold", {16'd0, out_data[s]}, {16'd0, exp_d});
    end
    chk("result", {16'd0, out_data[s]}, {16'd0, exp_d});
    $display("op inst=%0d data=%h cnt=%0d op=%0d -> %h (exp %h) lat_edges=%0d",
             s, d, c, o, out_data[s], exp_d, edges);
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
    chk("idle_after_pop_valid", {31'd0, out_valid[s]}, 32'd0);
    chk("idle_after_pop_ready", {31'd0, in_ready[s]}, 32'd1);
  endtask

  initial begin
    int edges;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    in_cnt    = '0;
    in_op     = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready",  {31'd0, in_ready[s]},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid[s]}, 32'd0);
      chk("rst_busy",      {31'd0, busy[s]},      32'd0);
      chk("rst_out_data",  {16'd0, out_data[s]},  32'd0);
    end

    // 1: SLL 0x0001 by 15, full-length run (5 cycles -> 4 edges)
    run_op(0, 16'h0001, 4'd15, 2'b01, 0);
    // 2: early exit
    run_op(1, 16'h8001, 4'd1,  2'b00, 0);   // 0x0003
    run_op(1, 16'h0001, 4'd4,  2'b10, 1);   // 0x1000
    // 3: right shifts/rotates
    run_op(1, 16'h8000, 4'd15, 2'b11, 0);   // 0x0001
    run_op(1, 16'hFFFF, 4'd8,  2'b11, 2);   // 0x00FF
    run_op(1, 16'h1234, 4'd8,  2'b10, 0);   // 0x3412
    run_op(0, 16'h1234, 4'd8,  2'b10, 0);   // 0x3412, full-length
    // 4: count of zero on every op
    for (int o = 0; o < 4; o++) begin
      run_op(1, 16'hA5A5, 4'd0, 2'(o), 0);
      run_op(0, 16'hA5A5, 4'd0, 2'(o), 0);
    end

    // 5: stall in DONE with a request pending
    in_valid[1] = 1'b1;
    in_data[1]  = 16'h00F0;
    in_cnt[1]   = 4'd4;
    in_op[1]    = 2'b01;
    tick();
    wait_valid(1, edges);
    chk("stall_latency", edges, 3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data",     {16'd0, out_data[1]}, 32'h0F00);
      chk("stall_in_ready", {31'd0, in_ready[1]}, 32'd0);
      chk("stall_valid",    {31'd0, out_valid[1]}, 32'd1);
      tick();
    end
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    chk("pop_no_accept_ready", {31'd0, in_ready[1]}, 32'd1);
    chk("pop_no_accept_busy",  {31'd0, busy[1]},     32'd0);
    tick();
    chk("accept_after_pop", {31'd0, busy[1]}, 32'd1);
    in_valid[1] = 1'b0;
    wait_valid(1, edges);
    chk("second_latency", edges, 3);
    chk("second_result", {16'd0, out_data[1]}, 32'h0F00);
    $display("stall test inst=1 result=%h", out_data[1]);
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;

    // 6: reset in the middle of RUN
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0001;
    in_cnt[0]   = 4'd15;
    in_op[0]    = 2'b01;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  {31'd0, in_ready[0]},  32'd1);
    chk("midrst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("midrst_busy",      {31'd0, busy[0]},      32'd0);
    chk("midrst_out_data",  {16'd0, out_data[0]},  32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_valid", {31'd0, out_valid[0]}, 32'd0);
    end
    $display("mid-run reset inst=0 dropped op, idle=%0d", in_ready[0]);
    run_op(0, 16'hC003, 4'd3, 2'b00, 0);    // 0x001E

    // Random ops on both instances
    for (int i = 0; i < 24; i++) begin
      run_op(i % 2, 16'($urandom), 4'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
